// File: rtl/cyber_player_if.sv
// Button-side bus of the automated tug-of-war opponent.
// The master drives the rate strobe and settings; the slave (the player) returns the button level.
interface cyber_player_if;
    logic       enable;
    logic [8:0] difficulty;
    logic       freeze;
    logic       key_n;
    logic       press_pulse;
    logic [9:0] lfsr_q;

    modport master (
        output enable, difficulty, freeze,
        input  key_n, press_pulse, lfsr_q
    );

    modport slave (
        input  enable, difficulty, freeze,
        output key_n, press_pulse, lfsr_q
    );
endinterface

// File: rtl/cyber_player.sv
// Automated opponent: an LFSR compared against a difficulty threshold decides when to press.
// Each press is a held active-low level followed by a mandatory release gap.
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | released, a press may start on the next tick
// ST_PRESS  | key_n held low for HOLD ticks
// ST_GAP    | key_n held high for GAP ticks before re-arming
module cyber_player #(
    parameter int HOLD = 2,
    parameter int GAP  = 4
) (
    input  logic           clk,
    input  logic           reset,
    cyber_player_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // A value of 8 truncates to 0, which the counter reaches by wrapping after 7.
    localparam logic [2:0] HOLD_C = 3'(HOLD);
    localparam logic [2:0] GAP_C  = 3'(GAP);

    logic [9:0] lfsr_q, lfsr_d;
    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       key_n_q, key_n_d;
    logic       pulse_q, pulse_d;
    logic       hit;

    assign hit = (lfsr_q < {1'b0, bus.difficulty});

    always_comb begin
        lfsr_d = lfsr_q;
        if (bus.enable) begin
            if (lfsr_q == 10'h000) lfsr_d = 10'h001;
            else                   lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_n_d = key_n_q;
        pulse_d = 1'b0;
        if (bus.freeze) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            key_n_d = 1'b1;
        end else if (bus.enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        state_d = ST_PRESS;
                        key_n_d = 1'b0;
                        pulse_d = 1'b1;
                        cnt_d   = 3'd1;
                    end
                end
                ST_PRESS: begin
                    if (cnt_q == HOLD_C) begin
                        state_d = ST_GAP;
                        key_n_d = 1'b1;
                        cnt_d   = 3'd1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_GAP: begin
                    key_n_d = 1'b1;
                    if (cnt_q == GAP_C) state_d = ST_IDLE;
                    else                cnt_d   = cnt_q + 3'd1;
                end
                default: begin
                    state_d = ST_IDLE;
                    key_n_d = 1'b1;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q  <= 10'h001;
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            key_n_q <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_n_q <= key_n_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.key_n       = key_n_q;
    assign bus.press_pulse = pulse_q;
    assign bus.lfsr_q      = lfsr_q;

endmodule

// File: tb/tb_cyber_player.sv
// Directed bench for cyber_player: a tick-based reference model pushes expected outputs to a
// scoreboard each cycle; directed checks cover reset, LFSR sequence, press timing, freeze and integration.
module tb_cyber_player;

    localparam int HOLD = 2;
    localparam int GAP  = 4;

    typedef struct packed {
        logic       key_n;
        logic       pulse;
        logic [9:0] lfsr;
    } exp_t;

    logic clk;
    logic reset;
    cyber_player_if cp_if ();

    cyber_player #(.HOLD(HOLD), .GAP(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (cp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    // Reference model state: mode 0 idle, 1 press, 2 gap; left = ticks remaining in the phase.
    logic       m_key;
    logic       m_pulse;
    logic [9:0] m_lfsr;
    int         m_mode;
    int         m_left;

    // Downstream meta -> userInput chain, counting pulses on both sides.
    logic m1, m2, m3, ui;
    logic integ_on = 1'b0;
    int   n_pp = 0;
    int   n_ui = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m1 <= 1'b1; m2 <= 1'b1; m3 <= 1'b1; ui <= 1'b0;
        end else begin
            m1 <= cp_if.key_n;
            m2 <= m1;
            m3 <= m2;
            ui <= m3 & ~m2;
        end
    end

    always @(negedge clk) begin
        if (integ_on) begin
            if (cp_if.press_pulse) n_pp++;
            if (ui) n_ui++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_key = 1'b1; m_pulse = 1'b0; m_lfsr = 10'h001; m_mode = 0; m_left = 0;
    endtask

    task automatic model_step(input logic en);
        logic [9:0] cur;
        cur     = m_lfsr;
        m_pulse = 1'b0;
        if (en) m_lfsr = (cur == 10'd0) ? 10'd1 : {cur[8:0], cur[9] ^ cur[6]};
        if (cp_if.freeze) begin
            m_mode = 0; m_key = 1'b1; m_left = 0;
        end else if (en) begin
            if (m_mode == 0) begin
                if (cur < {1'b0, cp_if.difficulty}) begin
                    m_mode = 1; m_key = 1'b0; m_pulse = 1'b1; m_left = HOLD;
                end
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) begin m_mode = 2; m_key = 1'b1; m_left = GAP; end
            end else begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end
    endtask

    // Drive one clock cycle, predict, then compare the scoreboard head after the edge.
    task automatic cyc(input logic en);
        exp_t e;
        cp_if.enable = en;
        model_step(en);
        sb.push_back('{key_n: m_key, pulse: m_pulse, lfsr: m_lfsr});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_key_n", 32'(cp_if.key_n), 32'(e.key_n));
        chk("sb_press_pulse", 32'(cp_if.press_pulse), 32'(e.pulse));
        chk("sb_lfsr", 32'(cp_if.lfsr_q), 32'(e.lfsr));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cp_if.enable = 1'b0;
        cp_if.freeze = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int seq [7] = '{2, 4, 8, 16, 32, 64, 129};
        logic key_t [1:8];
        logic pul_t [1:8];
        int   lows, pulses, found;

        reset = 1'b1;
        cp_if.enable = 1'b0;
        cp_if.difficulty = 9'd0;
        cp_if.freeze = 1'b0;
        #1;
        chk("rst_key_n", 32'(cp_if.key_n), 32'd1);
        chk("rst_press_pulse", 32'(cp_if.press_pulse), 32'd0);
        chk("rst_lfsr", 32'(cp_if.lfsr_q), 32'h001);

        // LFSR sequence and full period with no presses
        do_reset();
        cp_if.difficulty = 9'd0;
        for (int i = 1; i <= 1023; i++) begin
            cyc(1'b1);
            if (i <= 7) chk("lfsr_seq", 32'(cp_if.lfsr_q), 32'(seq[i-1]));
            if (i == 1022) chk("lfsr_not_early", 32'(cp_if.lfsr_q != 10'h001), 32'd1);
            if (i == 1023) chk("lfsr_period", 32'(cp_if.lfsr_q), 32'h001);
        end

        // Single press with continuous enable
        do_reset();
        cp_if.difficulty = 9'd3;
        for (int t = 1; t <= 8; t++) begin
            cyc(1'b1);
            key_t[t] = cp_if.key_n;
            pul_t[t] = cp_if.press_pulse;
        end
        chk("sp_t1_key", 32'(key_t[1]), 32'd0);
        chk("sp_t1_pulse", 32'(pul_t[1]), 32'd1);
        chk("sp_t2_key", 32'(key_t[2]), 32'd0);
        chk("sp_t2_pulse", 32'(pul_t[2]), 32'd0);
        chk("sp_t3_key", 32'(key_t[3]), 32'd1);
        chk("sp_t8_key", 32'(key_t[8]), 32'd1);
        chk("sp_t8_pulse", 32'(pul_t[8]), 32'd0);

        // Strobe gating: enable every 5th cycle, press lasts 10 clk cycles
        do_reset();
        cp_if.difficulty = 9'd3;
        lows = 0; pulses = 0;
        for (int c = 0; c < 60; c++) begin
            cyc(c % 5 == 0);
            if (!cp_if.key_n) lows++;
            if (cp_if.press_pulse) pulses++;
        end
        chk("strobe_low_cycles", 32'(lows), 32'd10);
        chk("strobe_pulses", 32'(pulses), 32'd1);

        // Reset in the middle of a press acts without a clock edge
        do_reset();
        cp_if.difficulty = 9'd511;
        cyc(1'b1);
        chk("mid_press_key", 32'(cp_if.key_n), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_key_n", 32'(cp_if.key_n), 32'd1);
        chk("async_rst_pulse", 32'(cp_if.press_pulse), 32'd0);
        chk("async_rst_lfsr", 32'(cp_if.lfsr_q), 32'h001);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Freeze aborts a press, blocks new ones, then presses resume
        cp_if.difficulty = 9'd511;
        cyc(1'b1);
        chk("frz_press_started", 32'(cp_if.press_pulse), 32'd1);
        cp_if.freeze = 1'b1;
        cyc(1'b1);
        chk("frz_key_release", 32'(cp_if.key_n), 32'd1);
        pulses = 0;
        for (int c = 0; c < 200; c++) begin
            cyc(c % 3 != 0);
            if (cp_if.press_pulse) pulses++;
        end
        chk("frz_no_pulse", 32'(pulses), 32'd0);
        cp_if.freeze = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            cyc(1'b1);
            if (cp_if.press_pulse) found = 1;
        end
        chk("frz_resume", 32'(found), 32'd1);

        // Integration with downstream synchroniser and edge detector
        do_reset();
        cp_if.difficulty = 9'd511;
        integ_on = 1'b1;
        for (int c = 0; c < 2000; c++) cyc(1'b1);
        cp_if.difficulty = 9'd0;
        for (int c = 0; c < 12; c++) cyc(1'b1);
        integ_on = 1'b0;
        chk("integ_some_presses", 32'(n_pp > 20), 32'd1);
        chk("integ_one_to_one", 32'(n_ui), 32'(n_pp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cyber_player.md
# cyber_player

Automated opponent for the two-button light tug-of-war. It drives the same button interface a human does, so it can replace one `KEY`-side player at the input of the metastability/`userInput` chain with no change downstream. A 10-bit LFSR and a switch-selected difficulty decide when to press. Each press is a clean, held, active-low button level, followed by a mandatory release gap, so the downstream edge detector sees exactly one press.

## Interface
Parameters:
- `HOLD`, default 2: number of `enable` ticks the button stays pressed (must be ≥ 1).
- `GAP`, default 4: number of `enable` ticks the button stays released after a press before another press is possible (must be ≥ 1).

Ports:
- `clk`, input, 1: system clock (`CLOCK_50` at top level).
- `reset`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: one-cycle rate strobe. All state advances only on cycles where `enable` = 1.
- `difficulty`, input, 9: press threshold, driven from `SW[8:0]`, unsigned.
- `freeze`, input, 1: game over. Suppresses presses and forces the button released.
- `key_n`, output, 1: button level with `KEY` polarity (1 = not pressed, 0 = pressed). Registered.
- `press_pulse`, output, 1: 1 for exactly one `clk` cycle, the first cycle `key_n` = 0 for each press. Registered.
- `lfsr_q`, output, 10: current LFSR state, for debug.

## Operation
- **LFSR:** Fibonacci, polynomial x^10+x^7+1. On each `enable` cycle: `lfsr_q <= {lfsr_q[8:0], lfsr_q[9]^lfsr_q[6]}`.
  - Period is 1023; the value is never 0.
  - If the value is ever 0 (illegal), it loads 10'h001 on the next `enable`.
  - The LFSR advances regardless of FSM state and `freeze`.
- **Decision:** `hit = (lfsr_q < {1'b0, difficulty})`, an unsigned 10-bit compare that uses the pre-update `lfsr_q`.
  - `difficulty` = 0 never presses.
  - `difficulty` = 511 presses on about 50% of eligible ticks.
- **FSM states:** IDLE, PRESS, GAP. One tick counter, 3 bits wide, sized for `HOLD`/`GAP` ≤ 8.
  - IDLE: on `enable` && `hit` && !`freeze` → PRESS. At that edge: `key_n` <= 0, `press_pulse` <= 1, counter <= 1.
  - PRESS: on `enable`:
    - If counter == `HOLD` → GAP. At that edge: `key_n` <= 1, counter <= 1.
    - Else counter increments.
  - GAP: on `enable`:
    - If counter == `GAP` → IDLE.
    - Else counter increments.
    - `key_n` stays 1.
- **`press_pulse`:** cleared on every cycle after the cycle it is set. It is never set outside the IDLE→PRESS transition.
- **`freeze` = 1:** at the next `clk` edge the state → IDLE, `key_n` <= 1, `press_pulse` <= 0, counter <= 0. This happens independent of `enable`.
  - A press in progress is aborted.
  - No new press starts while `freeze` = 1.
- **`difficulty` changes:** take effect at the next IDLE decision. They never affect a press already in progress.

## Timing
- **Reset values:** `key_n` = 1, `press_pulse` = 0, `lfsr_q` = 10'h001, state IDLE, counter 0. These apply immediately on `reset` assertion (asynchronous).
- **Decision-to-output latency:** 1 `clk` cycle. `key_n` falls on the edge that samples `enable` && `hit`.
- **Press length:** `key_n` = 0 for exactly `HOLD` `enable` ticks. The decision tick starts the press, and the release happens at the `HOLD`-th following tick.
- **Minimum spacing:** the decision tick plus `HOLD` + `GAP` ticks, i.e. with defaults the earliest next press is decided 7 ticks after the previous one.
- **`enable` held high continuously:** the block behaves as tick = `clk` cycle; this is the bench mode.
- **Reset mid-press:** `key_n` returns to 1 asynchronously, and `press_pulse` is dropped in the same cycle.
- **`freeze` and `hit` on the same cycle:** `freeze` wins; no pulse is produced.

## Test plan
- **Reset:** assert `reset` at an arbitrary time, mid-press → `key_n` = 1, `press_pulse` = 0, `lfsr_q` = 10'h001 with no clock edge needed.
- **LFSR sequence:** `difficulty` = 0, `enable` = 1 → `lfsr_q` steps 1, 2, 4, 8, 16, 32, 64, 129. `key_n` stays 1 throughout; the period of 1023 is confirmed by returning to 10'h001.
- **Single press:** `difficulty` = 3, `enable` = 1, `HOLD` = 2, `GAP` = 4.
  - Tick 1 (`lfsr_q` = 1) → `key_n` = 0 and `press_pulse` = 1 for one cycle.
  - `key_n` = 0 through tick 3, back to 1 after tick 3.
  - Ticks 4–7 are GAP. Tick 8 (`lfsr_q` = 129) → no press.
- **Strobe gating:** same setup as the single press, but `enable` pulses every 5th cycle → identical tick-indexed behaviour. `key_n` low for exactly 10 `clk` cycles.
- **Freeze:** `difficulty` = 511; assert `freeze` during PRESS → `key_n` = 1 on the next edge. No `press_pulse` for 200 cycles while `freeze` = 1. Presses resume after `freeze` = 0.
- **Integration:** `cyber_player.key_n` drives `meta` → `userInput` in place of `KEY[0]`, with `difficulty` = 511 → each `press_pulse` yields exactly one downstream `userInput` output pulse, with no double-counts over 2000 cycles.
